// File: rtl/usb_tx_pkt_pkg.sv
// ---------------------------------------------------------------------------
// usb_tx_pkt_pkg
// Shared definitions for the USB packet transmit sequencer:
//   - FSM state encoding
//   - PID constants (4-bit PID field; the wire byte is {~pid, pid})
//   - CRC16 polynomial, init value and receiver residual
//   - small helpers for PID classification and PID byte construction
// ---------------------------------------------------------------------------
package usb_tx_pkt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_DATA,
        ST_CRC_LO,
        ST_CRC_HI,
        ST_WAIT
    } tx_state_t;

    // SYNC pattern, sent LSB first: 0000_0001 on the wire
    localparam logic [7:0] SYNC_BYTE = 8'h80;

    // Token PIDs
    localparam logic [3:0] PID_OUT   = 4'h1;
    localparam logic [3:0] PID_IN    = 4'h9;
    localparam logic [3:0] PID_SOF   = 4'h5;
    localparam logic [3:0] PID_SETUP = 4'hD;
    // Data PIDs (low two bits 2'b11)
    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hB;
    localparam logic [3:0] PID_DATA2 = 4'h7;
    localparam logic [3:0] PID_MDATA = 4'hF;
    // Handshake PIDs
    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_NAK   = 4'hA;
    localparam logic [3:0] PID_STALL = 4'hE;
    localparam logic [3:0] PID_NYET  = 4'h6;

    localparam logic [15:0] CRC16_POLY     = 16'h8005;
    localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

    function automatic logic is_data_pid(input logic [3:0] pid);
        return (pid[1:0] == 2'b11);
    endfunction

    function automatic logic [7:0] pid_byte(input logic [3:0] pid);
        return {~pid, pid};
    endfunction

endpackage

// File: rtl/usb_tx_pkt_crc16.sv
// ---------------------------------------------------------------------------
// usb_tx_crc16
// Serial CRC16 generator for the USB transmit path.
//   clk, rst      : clock, asynchronous active-high reset (crc -> init value)
//   init          : reload the register with the init value
//   en_upd, din   : fold one payload bit (din) into the CRC
//   en_shift      : shift the register left by one while the CRC is sent
//   crc_msb       : current crc[15]; the transmitted CRC bit is its inverse
// init has priority over en_upd, which has priority over en_shift.
// ---------------------------------------------------------------------------
module usb_tx_crc16
    import usb_tx_pkt_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic init,
    input  logic en_upd,
    input  logic en_shift,
    input  logic din,
    output logic crc_msb
);

    logic [15:0] crc_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_reg <= CRC16_INIT;
        end else if (init) begin
            crc_reg <= CRC16_INIT;
        end else if (en_upd) begin
            crc_reg <= {crc_reg[14:0], 1'b0} ^ ((din ^ crc_reg[15]) ? CRC16_POLY : 16'h0000);
        end else if (en_shift) begin
            crc_reg <= {crc_reg[14:0], 1'b0};
        end
    end

    assign crc_msb = crc_reg[15];

endmodule

// File: rtl/usb_tx_pkt.sv
// ---------------------------------------------------------------------------
// usb_tx_pkt
// Packet-level USB transmit sequencer above the bit-level driver.
// Serializes SYNC, PID, optional payload and CRC16 one bit per ll_ack, then
// holds busy for EOP_WAIT cycles so the EOP can leave the line.
//   EOP_WAIT     : cycles from the final ll_ack to pkt_done (>= 2)
//   clk, rst     : clock, asynchronous active-high reset
//   pkt_start    : request, accepted only in IDLE
//   pkt_pid      : 4-bit PID, sampled on accepted start
//   pkt_len      : payload byte count (data PIDs only), sampled with pkt_pid
//   pkt_data     : current payload byte
//   pkt_data_ack : pulse in the cycle pkt_data is loaded
//   pkt_busy     : accepted start through pkt_done
//   pkt_done     : pulse, packet fully on the wire
//   ll_start     : pulse, packet begins at the bit driver
//   ll_bit       : bit offered (unencoded, LSB first)
//   ll_last      : final bit of the packet is being offered
//   ll_ack       : pulse, offered bit consumed
// ---------------------------------------------------------------------------
module usb_tx_pkt
    import usb_tx_pkt_pkg::*;
#(
    parameter int EOP_WAIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pkt_start,
    input  logic [3:0] pkt_pid,
    input  logic [9:0] pkt_len,
    input  logic [7:0] pkt_data,
    output logic       pkt_data_ack,
    output logic       pkt_busy,
    output logic       pkt_done,
    output logic       ll_start,
    output logic       ll_bit,
    output logic       ll_last,
    input  logic       ll_ack
);

    localparam int WAIT_W = $clog2(EOP_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(EOP_WAIT - 1);

    tx_state_t         state_reg, state_next;
    logic [7:0]        sr_reg;
    logic [2:0]        bit_cnt_reg;
    logic [9:0]        byte_cnt_reg;   // bytes still to be loaded after the current one
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic [3:0]        pid_reg;
    logic              is_data_reg;
    logic              ll_start_reg;

    logic crc_init, crc_upd, crc_shift, crc_msb;
    logic bit_end;
    logic tx_active;

    assign bit_end   = ll_ack && (bit_cnt_reg == 3'd7);
    assign tx_active = (state_reg == ST_SYNC)   || (state_reg == ST_PID) ||
                       (state_reg == ST_DATA)   || (state_reg == ST_CRC_LO) ||
                       (state_reg == ST_CRC_HI);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next state and combinational outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        pkt_data_ack = 1'b0;
        pkt_done     = 1'b0;
        ll_bit       = 1'b0;
        ll_last      = 1'b0;
        crc_init     = 1'b0;
        crc_upd      = 1'b0;
        crc_shift    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (pkt_start) begin
                    state_next = ST_SYNC;
                    crc_init   = 1'b1;
                end
            end
            ST_SYNC: begin
                ll_bit = sr_reg[0];
                if (bit_end) begin
                    state_next = ST_PID;
                end
            end
            ST_PID: begin
                ll_bit  = sr_reg[0];
                ll_last = !is_data_reg && (bit_cnt_reg == 3'd7);
                if (bit_end) begin
                    if (!is_data_reg) begin
                        state_next = ST_WAIT;
                    end else if (byte_cnt_reg == 10'd0) begin
                        state_next = ST_CRC_LO;
                    end else begin
                        // first payload byte goes into sr on the last PID bit
                        state_next   = ST_DATA;
                        pkt_data_ack = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                ll_bit  = sr_reg[0];
                crc_upd = ll_ack;
                if (bit_end) begin
                    if (byte_cnt_reg == 10'd0) begin
                        state_next = ST_CRC_LO;
                    end else begin
                        pkt_data_ack = 1'b1;
                    end
                end
            end
            ST_CRC_LO: begin
                ll_bit    = ~crc_msb;
                crc_shift = ll_ack;
                if (bit_end) begin
                    state_next = ST_CRC_HI;
                end
            end
            ST_CRC_HI: begin
                ll_bit    = ~crc_msb;
                ll_last   = (bit_cnt_reg == 3'd7);
                crc_shift = ll_ack;
                if (bit_end) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_reg == '0) begin
                    pkt_done   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath: shift register, bit/byte counters, EOP wait counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_reg       <= 8'h00;
            bit_cnt_reg  <= 3'd0;
            byte_cnt_reg <= 10'd0;
            wait_cnt_reg <= '0;
            pid_reg      <= 4'h0;
            is_data_reg  <= 1'b0;
            ll_start_reg <= 1'b0;
        end else begin
            ll_start_reg <= (state_reg == ST_IDLE) && pkt_start;
            if ((state_reg == ST_IDLE) && pkt_start) begin
                sr_reg       <= SYNC_BYTE;
                bit_cnt_reg  <= 3'd0;
                byte_cnt_reg <= pkt_len;
                pid_reg      <= pkt_pid;
                is_data_reg  <= is_data_pid(pkt_pid);
            end else if (tx_active && ll_ack) begin
                if (bit_cnt_reg != 3'd7) begin
                    sr_reg      <= sr_reg >> 1;
                    bit_cnt_reg <= bit_cnt_reg + 3'd1;
                end else begin
                    bit_cnt_reg <= 3'd0;
                    if (state_reg == ST_SYNC) begin
                        sr_reg <= pid_byte(pid_reg);
                    end else if (pkt_data_ack) begin
                        sr_reg       <= pkt_data;
                        byte_cnt_reg <= byte_cnt_reg - 10'd1;
                    end
                    if (state_next == ST_WAIT) begin
                        wait_cnt_reg <= WAIT_LOAD;
                    end
                end
            end else if ((state_reg == ST_WAIT) && (wait_cnt_reg != '0)) begin
                wait_cnt_reg <= wait_cnt_reg - 1'b1;
            end
        end
    end

    assign ll_start = ll_start_reg;
    assign pkt_busy = (state_reg != ST_IDLE);

    usb_tx_crc16 u_crc16 (
        .clk      (clk),
        .rst      (rst),
        .init     (crc_init),
        .en_upd   (crc_upd),
        .en_shift (crc_shift),
        .din      (sr_reg[0]),
        .crc_msb  (crc_msb)
    );

endmodule

// File: tb/tb_usb_tx_pkt.sv
// ---------------------------------------------------------------------------
// tb_usb_tx_pkt
// Drives usb_tx_pkt as the bit-level driver would (one ll_ack per bit) and
// compares the serial stream with a byte-level packet model: SYNC, PID byte,
// payload, and a CRC16 computed with the reflected (0xA001) table-free form.
// ---------------------------------------------------------------------------
module tb_usb_tx_pkt;

    localparam int EOP_WAIT = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pkt_start = 1'b0;
    logic [3:0] pkt_pid = 4'h0;
    logic [9:0] pkt_len = 10'd0;
    logic [7:0] pkt_data = 8'h00;
    logic       pkt_data_ack;
    logic       pkt_busy;
    logic       pkt_done;
    logic       ll_start;
    logic       ll_bit;
    logic       ll_last;
    logic       ll_ack = 1'b0;

    int checks = 0;
    int failures = 0;
    logic [7:0] payload [1024];
    int data_idx;

    always #5 clk = ~clk;

    usb_tx_pkt #(.EOP_WAIT(EOP_WAIT)) dut (
        .clk          (clk),
        .rst          (rst),
        .pkt_start    (pkt_start),
        .pkt_pid      (pkt_pid),
        .pkt_len      (pkt_len),
        .pkt_data     (pkt_data),
        .pkt_data_ack (pkt_data_ack),
        .pkt_busy     (pkt_busy),
        .pkt_done     (pkt_done),
        .ll_start     (ll_start),
        .ll_bit       (ll_bit),
        .ll_last      (ll_last),
        .ll_ack       (ll_ack)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // USB CRC16 in reflected byte form; returns the 16 bits in wire order
    function automatic logic [15:0] crc16_wire(input int len);
        logic [15:0] r;
        r = 16'hFFFF;
        for (int b = 0; b < len; b++) begin
            r = r ^ {8'h00, payload[b]};
            for (int k = 0; k < 8; k++) begin
                r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
            end
        end
        return ~r;
    endfunction

    // One packet. busy_poke: bit index at which pkt_start is pulsed (-1 none);
    // done_poke: pulse pkt_start in the pkt_done cycle; abort_bit: bit index
    // at which rst is raised (-1 none); stuff_pct: chance of an extra gap.
    task automatic run_pkt(input logic [3:0] pid, input int len, input int busy_poke,
                           input bit done_poke, input int abort_bit, input int stuff_pct);
        logic exp_bits[$];
        logic obs_bits[$];
        logic [7:0] sync_b, pid_b;
        logic [15:0] crcw, rx;
        bit is_data, dack, exp_dack;
        int nbits, dacks, gap, n;
        is_data = (pid[1:0] == 2'b11);
        sync_b = 8'h80;
        pid_b = {~pid, pid};
        for (int k = 0; k < 8; k++) exp_bits.push_back(sync_b[k]);
        for (int k = 0; k < 8; k++) exp_bits.push_back(pid_b[k]);
        if (is_data) begin
            for (int b = 0; b < len; b++) begin
                sync_b = payload[b];
                for (int k = 0; k < 8; k++) exp_bits.push_back(sync_b[k]);
            end
            crcw = crc16_wire(len);
            for (int k = 0; k < 16; k++) exp_bits.push_back(crcw[k]);
        end
        nbits = exp_bits.size();
        dacks = 0;
        $display("pkt pid=0x%0h len=%0d bits=%0d", pid, len, nbits);

        // caller leaves us at a negedge
        pkt_pid = pid;
        pkt_len = 10'(len);
        pkt_start = 1'b1;
        data_idx = 0;
        pkt_data = payload[0];
        @(negedge clk);
        pkt_start = 1'b0;
        chk("ll_start_pulse", {31'd0, ll_start}, 32'd1);
        chk("busy_after_start", {31'd0, pkt_busy}, 32'd1);
        @(negedge clk);
        chk("ll_start_one_cycle", {31'd0, ll_start}, 32'd0);

        for (int i = 0; i < nbits; i++) begin
            if (i == abort_bit) begin
                #2 rst = 1'b1;
                #1 chk("outputs_in_reset",
                       {26'd0, ll_start, ll_bit, ll_last, pkt_data_ack, pkt_busy, pkt_done}, 32'd0);
                ll_ack = 1'b0;
                pkt_start = 1'b0;
                @(negedge clk);
                @(negedge clk);
                rst = 1'b0;
                chk("busy_after_reset", {31'd0, pkt_busy}, 32'd0);
                return;
            end
            chk($sformatf("ll_bit[%0d]", i), {31'd0, ll_bit}, {31'd0, exp_bits[i]});
            chk($sformatf("ll_last[%0d]", i), {31'd0, ll_last}, {31'd0, (i == nbits - 1)});
            obs_bits.push_back(ll_bit);
            if (i == busy_poke) begin
                pkt_start = 1'b1;
                pkt_pid = ~pid;
            end
            ll_ack = 1'b1;
            #1;
            dack = pkt_data_ack;
            exp_dack = is_data && (len > 0) &&
                       ((i == 15) || ((i >= 16) && (i < 16 + 8 * (len - 1)) && ((i - 16) % 8 == 7)));
            chk($sformatf("data_ack[%0d]", i), {31'd0, dack}, {31'd0, exp_dack});
            @(negedge clk);
            ll_ack = 1'b0;
            pkt_start = 1'b0;
            if (dack) begin
                dacks++;
                data_idx++;
                if (data_idx < 1024) pkt_data = payload[data_idx];
            end
            if (i == nbits - 1) break;
            gap = 3;
            if ($urandom_range(0, 99) < stuff_pct) gap += 4;
            repeat (gap) @(negedge clk);
        end

        chk("data_ack_count", dacks, (is_data && len > 0) ? len : 0);

        // now one cycle after the final ll_ack; count to pkt_done
        n = 0;
        while (!pkt_done && n < 100) begin
            if (n == 5) ll_ack = 1'b1;   // stray ack in WAIT must be ignored
            @(negedge clk);
            ll_ack = 1'b0;
            n++;
        end
        chk("done_latency", n, EOP_WAIT - 1);
        chk("busy_in_done", {31'd0, pkt_busy}, 32'd1);
        if (done_poke) pkt_start = 1'b1;
        @(negedge clk);
        pkt_start = 1'b0;
        chk("busy_after_done", {31'd0, pkt_busy}, 32'd0);
        chk("no_restart_after_done", {31'd0, ll_start}, 32'd0);

        if (is_data) begin
            rx = 16'hFFFF;
            for (int k = 16; k < obs_bits.size(); k++) begin
                rx = {rx[14:0], 1'b0} ^ ((obs_bits[k] ^ rx[15]) ? 16'h8005 : 16'h0000);
            end
            chk("crc_residual", {16'd0, rx}, 32'h0000_800D);
        end
    endtask

    initial begin
        for (int b = 0; b < 1024; b++) payload[b] = 8'($urandom);
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {26'd0, ll_start, ll_bit, ll_last, pkt_data_ack, pkt_busy, pkt_done}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_outputs",
            {26'd0, ll_start, ll_bit, ll_last, pkt_data_ack, pkt_busy, pkt_done}, 32'd0);

        // ACK handshake; len must be ignored for a non-data PID
        run_pkt(4'h2, 5, -1, 1'b0, -1, 0);
        // zero-length DATA1
        run_pkt(4'hB, 0, -1, 1'b0, -1, 0);
        // DATA0, payload 00 01 02 03, start pokes while busy and in done cycle
        for (int b = 0; b < 4; b++) payload[b] = 8'(b);
        run_pkt(4'h3, 4, 20, 1'b1, -1, 0);
        // accepted in the cycle right after the ignored done-cycle start
        run_pkt(4'hA, 0, -1, 1'b0, -1, 0);
        // reset during payload byte 2, then a clean packet
        for (int b = 0; b < 8; b++) payload[b] = 8'($urandom);
        run_pkt(4'h3, 6, -1, 1'b0, 16 + 16 + 3, 0);
        run_pkt(4'hB, 6, -1, 1'b0, -1, 0);
        // random PIDs and lengths
        for (int t = 0; t < 6; t++) begin
            for (int b = 0; b < 24; b++) payload[b] = 8'($urandom);
            run_pkt(4'($urandom), $urandom_range(0, 20), -1, 1'b0, -1, 10);
        end
        // maximum length with bit-stuff gaps
        for (int b = 0; b < 1024; b++) payload[b] = 8'($urandom);
        run_pkt(4'h7, 1023, -1, 1'b0, -1, 12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
